mc_control: RTL and testbench

- Multicycle control FSM for the MIPS core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC write-enable and next-PC source select, plus all datapath mux, ALU and register-file controls.
- Handles the unified memory's req/ready handshake and counts retired instructions.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/mc_alu_decode.sv | 19 +
 rtl/mc_control.sv | 145 ++++++++++++++
 tb/tb_mc_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct codes, multicycle state enum and datapath select encodings
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_WB_IMM, S_MEM_ADDR,
    S_MEM_RD, S_WB_LD, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] B_RT     = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;
  localparam logic [1:0] B_IMM_SH = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_ORZ = 3'b101;
endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational opcode/funct to ALU operation decode
module mc_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);
  logic [2:0] r_op;
  always_comb begin
    r_op = funct == FN_SUB ? ALU_SUB :
           funct == FN_AND ? ALU_AND :
           funct == FN_OR  ? ALU_OR  :
           funct == FN_SLT ? ALU_SLT : ALU_ADD;
    alu_op = opcode == OP_RTYPE ? r_op :
             opcode == OP_ORI   ? ALU_ORZ :
             (opcode == OP_BEQ || opcode == OP_BNE) ? ALU_SUB : ALU_ADD;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS control FSM with memory handshake and retired-instruction counter
module mc_control
  import mips_pkg::*;
#(
  parameter int ILLEGAL_TRAP = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic [3:0]       state
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] dec_op;
  logic legal;
  mc_alu_decode u_dec (.opcode(opcode), .funct(funct), .alu_op(dec_op));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // strobes are masked while rst is high so a pending memory request drops immediately
  always_comb begin
    state_d = S_FETCH;
    mem_req = 1'b0;
    mem_we = 1'b0;
    iord = 1'b0;
    ir_write = 1'b0;
    pc_en = 1'b0;
    pc_src = PC_SEQ;
    alu_src_a = 1'b0;
    alu_src_b = B_RT;
    alu_op = ALU_ADD;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    retire = 1'b0;
    halted = 1'b0;
    legal = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
    if (!rst)
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          alu_src_b = B_FOUR;
          ir_write = mem_ready;
          pc_en = mem_ready;
          state_d = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = B_IMM_SH;
          retire = !legal && ILLEGAL_TRAP == 0;
          state_d = opcode == OP_RTYPE ? S_EXEC_R :
                    (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                    (opcode == OP_BEQ || opcode == OP_BNE) ? S_BRANCH :
                    (opcode == OP_ADDI || opcode == OP_ORI) ? S_EXEC_I :
                    opcode == OP_J ? S_JUMP :
                    ILLEGAL_TRAP != 0 ? S_HALT : S_FETCH;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op = dec_op;
          state_d = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = B_IMM;
          alu_op = dec_op;
          state_d = S_WB_IMM;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
          retire = 1'b1;
        end
        S_WB_IMM: begin
          reg_write = 1'b1;
          retire = 1'b1;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = B_IMM;
          state_d = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord = 1'b1;
          state_d = mem_ready ? S_WB_LD : S_MEM_RD;
        end
        S_WB_LD: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          retire = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we = 1'b1;
          iord = 1'b1;
          retire = mem_ready;
          state_d = mem_ready ? S_FETCH : S_MEM_WR;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = dec_op;
          pc_src = PC_BR;
          pc_en = opcode == OP_BNE ? !zero : zero;
          retire = 1'b1;
        end
        S_JUMP: begin
          pc_en = 1'b1;
          pc_src = PC_JMP;
          retire = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_FETCH;
      endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end
  assign retired_cnt = cnt_q;
  assign state = state_q;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized instruction stream checked cycle-by-cycle against a per-instruction phase model
module tb_mc_control;
  import mips_pkg::*;
  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic reg_write, reg_dst, mem_to_reg, retire, halted;
    logic [3:0] state;
  } outs_t;
  typedef enum {P_F, P_D, P_XR, P_XI, P_WA, P_WI, P_MA, P_MR, P_WL, P_MW, P_BR, P_J} ph_t;
  logic clk = 0, rst = 1;
  logic [5:0] opcode = 0, funct = 0;
  logic zero = 0, mem_ready = 0;
  logic mem_req, mem_we, iord, ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg, retire, halted;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [31:0] retired_cnt;
  logic [3:0] state;
  logic h_mem_req, h_mem_we, h_iord, h_ir_write, h_pc_en, h_alu_src_a, h_reg_write, h_reg_dst, h_mem_to_reg, h_retire, h_halted;
  logic [1:0] h_pc_src, h_alu_src_b;
  logic [2:0] h_alu_op;
  logic [31:0] h_retired_cnt;
  logic [3:0] h_state;
  outs_t a0;
  int vecs = 0, errs = 0;
  logic [31:0] exp_cnt = 0;
  mc_control #(.ILLEGAL_TRAP(0), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire),
    .retired_cnt(retired_cnt), .halted(halted), .state(state)
  );
  mc_control #(.ILLEGAL_TRAP(1), .CNT_W(32)) dut_trap (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .mem_we(h_mem_we), .iord(h_iord), .ir_write(h_ir_write), .pc_en(h_pc_en),
    .pc_src(h_pc_src), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .alu_op(h_alu_op),
    .reg_write(h_reg_write), .reg_dst(h_reg_dst), .mem_to_reg(h_mem_to_reg), .retire(h_retire),
    .retired_cnt(h_retired_cnt), .halted(h_halted), .state(h_state)
  );
  assign a0 = {mem_req, mem_we, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op,
               reg_write, reg_dst, mem_to_reg, retire, halted, state};
  always #5 clk = ~clk;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};
  endfunction
  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    if (fn == 6'h22) return 3'b001;
    if (fn == 6'h24) return 3'b010;
    if (fn == 6'h25) return 3'b011;
    if (fn == 6'h2A) return 3'b100;
    return 3'b000;
  endfunction
  function automatic outs_t expect_o(input ph_t p, input logic [5:0] op, fn, input logic z, rdy);
    outs_t e = '0;
    case (p)
      P_F:  begin e.state = S_FETCH; e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_en = rdy; end
      P_D:  begin e.state = S_DECODE; e.alu_src_b = 2'b11; e.retire = !is_legal(op); end
      P_XR: begin e.state = S_EXEC_R; e.alu_src_a = 1; e.alu_op = r_alu(fn); end
      P_XI: begin e.state = S_EXEC_I; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = op == 6'h0D ? 3'b101 : 3'b000; end
      P_WA: begin e.state = S_WB_ALU; e.reg_write = 1; e.reg_dst = 1; e.retire = 1; end
      P_WI: begin e.state = S_WB_IMM; e.reg_write = 1; e.retire = 1; end
      P_MA: begin e.state = S_MEM_ADDR; e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      P_MR: begin e.state = S_MEM_RD; e.mem_req = 1; e.iord = 1; end
      P_WL: begin e.state = S_WB_LD; e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
      P_MW: begin e.state = S_MEM_WR; e.mem_req = 1; e.mem_we = 1; e.iord = 1; e.retire = rdy; end
      P_BR: begin e.state = S_BRANCH; e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_en = op == 6'h05 ? !z : z; e.retire = 1; end
      default: begin e.state = S_JUMP; e.pc_en = 1; e.pc_src = 2'b10; e.retire = 1; end
    endcase
    return e;
  endfunction
  // fields the spec leaves open in a given phase are masked out
  function automatic outs_t care(input ph_t p, input outs_t e);
    outs_t m = '0;
    m.mem_req = 1; m.mem_we = 1; m.ir_write = 1; m.pc_en = 1; m.reg_write = 1; m.retire = 1; m.halted = 1; m.state = '1;
    if (e.mem_req) m.iord = 1;
    if (e.pc_en || p == P_BR) m.pc_src = '1;
    if (e.reg_write) begin m.reg_dst = 1; m.mem_to_reg = 1; end
    if (p inside {P_F, P_D, P_XR, P_XI, P_MA, P_BR}) begin m.alu_src_a = 1; m.alu_src_b = '1; m.alu_op = '1; end
    return m;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic run_instr(input logic [5:0] op, fn, input logic z, input int fw, mw,
                           output int cyc, nmr, npc, nwe);
    ph_t q[$];
    int i, w;
    logic wp;
    outs_t e, m;
    q = '{P_F, P_D};
    case (op)
      6'h00: begin q.push_back(P_XR); q.push_back(P_WA); end
      6'h23: begin q.push_back(P_MA); q.push_back(P_MR); q.push_back(P_WL); end
      6'h2B: begin q.push_back(P_MA); q.push_back(P_MW); end
      6'h04, 6'h05: q.push_back(P_BR);
      6'h08, 6'h0D: begin q.push_back(P_XI); q.push_back(P_WI); end
      6'h02: q.push_back(P_J);
      default: ;
    endcase
    opcode = op; funct = fn; zero = z;
    cyc = 0; nmr = 0; npc = 0; nwe = 0; i = 0; w = 0;
    while (i < q.size()) begin
      wp = q[i] inside {P_F, P_MR, P_MW};
      mem_ready = wp ? (w >= (q[i] == P_F ? fw : mw)) : 1'($urandom);
      @(negedge clk);
      e = expect_o(q[i], op, fn, z, mem_ready);
      m = care(q[i], e);
      vecs++;
      if (((a0 ^ e) & m) !== '0) begin
        errs++;
        $display("FAIL outputs op=%h phase=%0d: got %h want %h mask %h", op, q[i], a0, e, m);
      end
      chk("retired_cnt", retired_cnt, exp_cnt);
      exp_cnt += 32'(e.retire);
      cyc++;
      nmr += int'(mem_req && iord);
      npc += int'(pc_en);
      nwe += int'(mem_we);
      @(posedge clk); #1;
      if (wp && !mem_ready) w++;
      else begin i++; w = 0; end
    end
  endtask
  initial begin
    int cyc, nmr, npc, nwe;
    logic [5:0] op, fn;
    logic [5:0] legal_ops[8];
    logic [5:0] fns[5];
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_trap_halted", 32'(h_halted), 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_mem_req", 32'(mem_req), 1);
    @(posedge clk); #1;
    run_instr(6'h00, 6'h20, 0, 0, 0, cyc, nmr, npc, nwe);
    chk("add_cycles", cyc, 4);
    chk("add_cnt", retired_cnt, 1);
    run_instr(6'h23, 6'h00, 0, 0, 3, cyc, nmr, npc, nwe);
    chk("lw_cycles", cyc, 8);
    chk("lw_mem_req_cycles", nmr, 4);
    run_instr(6'h04, 6'h00, 1, 0, 0, cyc, nmr, npc, nwe);
    chk("beq_cycles", cyc, 3);
    chk("beq_pc_en", npc, 2);
    run_instr(6'h05, 6'h00, 1, 0, 0, cyc, nmr, npc, nwe);
    chk("bne_cycles", cyc, 3);
    chk("bne_pc_en", npc, 1);
    chk("br_cnt", retired_cnt, 4);
    run_instr(6'h02, 6'h00, 0, 0, 0, cyc, nmr, npc, nwe);
    chk("j_cycles", cyc, 3);
    chk("j_pc_en", npc, 2);
    run_instr(6'h2B, 6'h00, 0, 0, 0, cyc, nmr, npc, nwe);
    chk("sw_cycles", cyc, 4);
    chk("sw_mem_we", nwe, 1);
    chk("sw_cnt", retired_cnt, 6);
    run_instr(6'h3F, 6'h00, 0, 0, 0, cyc, nmr, npc, nwe);
    chk("illegal_cycles", cyc, 2);
    chk("illegal_cnt", retired_cnt, 7);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(9) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else op = legal_ops[$urandom_range(7)];
      fn = $urandom_range(3) == 0 ? 6'($urandom) : fns[$urandom_range(4)];
      run_instr(op, fn, 1'($urandom), $urandom_range(3), $urandom_range(3), cyc, nmr, npc, nwe);
    end
    mem_ready = 1;
    opcode = 6'h23;
    repeat (3) @(posedge clk);
    #1 mem_ready = 0;
    @(negedge clk);
    chk("lw_wait_req", {30'b0, mem_req, iord}, 3);
    #2 rst = 1;
    #1;
    chk("async_rst_req", 32'(mem_req), 0);
    chk("async_rst_state", 32'(state), 32'(S_FETCH));
    chk("async_rst_cnt", retired_cnt, 0);
    @(posedge clk); #1;
    rst = 0;
    exp_cnt = 0;
    run_instr(6'h3F, 6'h00, 0, 0, 0, cyc, nmr, npc, nwe);
    chk("illegal_nop_cnt", retired_cnt, 1);
    for (int k = 0; k < 100; k++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk("halt_hold", {25'b0, h_halted, h_mem_req, h_retire, h_state}, {25'b0, 3'b100, 4'(S_HALT)});
      @(posedge clk); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
